// File: rtl/video_to_fifo_ctrl.sv
// video_to_fifo_ctrl: packs 24-bit RGB pixels four per FIFO word and issues one burst request per line.
// Error flags are live only when VIDEO_TO_FIFO_ERR_EN is defined; otherwise they read 0.
module video_to_fifo_ctrl #(
  parameter logic [11:0] H_DISP          = 12'd1920,
  parameter logic [11:0] V_DISP          = 12'd1080,
  parameter int unsigned AXI4_DATA_WIDTH = 128,
  parameter int unsigned FIFO_RST_CYCLES = 8
) (
  input  logic                       video_clk,
  input  logic                       video_rst_n,
  input  logic                       video_vs_in,
  input  logic                       video_hs_in,
  input  logic                       video_de_in,
  input  logic [23:0]                video_data_in,
  output logic [AXI4_DATA_WIDTH-1:0] fifo_data_out,
  output logic                       fifo_wr_en,
  input  logic                       fifo_full,
  output logic                       fifo_rst_n,
  output logic                       AXI_FULL_BURST_VALID,
  input  logic                       AXI_FULL_BURST_READY,
  output logic                       frame_done,
  output logic                       err_overflow,
  output logic                       err_burst_overrun,
  input  logic                       err_clr
);

`ifdef VIDEO_TO_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {WAIT_VS, ACTIVE, LINE_REQ, FRAME_END} state_e;

  state_e state_q, state_d;

  logic        vs_r_q, vs_d1_q, de_r_q, de_d1_q, full_r_q, clr_r_q;
  logic [23:0] data_r_q;

  logic [11:0]                pix_cnt_q, pix_cnt_d;
  logic [11:0]                line_cnt_q, line_cnt_d;
  logic [3:0][23:0]           pix_buf_q, pix_buf_d;
  logic [AXI4_DATA_WIDTH-1:0] data_q, data_d;
  logic                       wr_en_q, wr_en_d;
  logic                       valid_q, valid_d;
  logic                       fifo_rst_n_q, fifo_rst_n_d;
  logic [15:0]                rst_cnt_q, rst_cnt_d;
  logic                       err_ovf_q, err_ovf_d;
  logic                       err_bov_q, err_bov_d;

  logic                       vs_rise, de_fall, line_req, emit, wr_ok;
  logic                       ovf_evt, bov_evt;
  logic [1:0]                 slot;
  logic [3:0][23:0]           grp;
  logic [AXI4_DATA_WIDTH-1:0] word;
  logic                       unused_hs;

  assign unused_hs = video_hs_in;

  assign vs_rise = vs_r_q & ~vs_d1_q;
  assign de_fall = de_d1_q & ~de_r_q;

  // FIFO reset pulse: low for FIFO_RST_CYCLES cycles starting the cycle after a VS rise
  always_comb begin
    rst_cnt_d    = rst_cnt_q;
    fifo_rst_n_d = 1'b1;
    if (vs_rise) begin
      rst_cnt_d    = 16'(FIFO_RST_CYCLES - 1);
      fifo_rst_n_d = 1'b0;
    end else if (rst_cnt_q != '0) begin
      rst_cnt_d    = rst_cnt_q - 16'd1;
      fifo_rst_n_d = 1'b0;
    end else begin
      rst_cnt_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    line_req   = 1'b0;
    case (state_q)
      WAIT_VS:   state_d = WAIT_VS;
      ACTIVE: begin
        if (de_fall) begin
          state_d    = LINE_REQ;
          line_cnt_d = line_cnt_q + 12'd1;
          line_req   = 1'b1;
        end
      end
      LINE_REQ:  state_d = (line_cnt_q < V_DISP) ? ACTIVE : FRAME_END;
      FRAME_END: state_d = WAIT_VS;
      default:   state_d = WAIT_VS;
    endcase
    if (vs_rise) begin
      state_d    = ACTIVE;
      line_cnt_d = '0;
      line_req   = 1'b0;
    end
  end

  // Packer: slot 0 (first pixel) lands in the most significant 32-bit lane
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    pix_buf_d = pix_buf_q;
    emit      = 1'b0;
    slot      = pix_cnt_q[1:0];
    grp       = pix_buf_q;
    if (vs_rise || !de_r_q) begin
      pix_cnt_d = '0;
      pix_buf_d = '0;
    end else if (pix_cnt_q < H_DISP) begin
      grp[slot] = data_r_q;
      pix_cnt_d = pix_cnt_q + 12'd1;
      if (slot == 2'd3 || pix_cnt_q == H_DISP - 12'd1) begin
        emit      = 1'b1;
        pix_buf_d = '0;
      end else begin
        pix_buf_d = grp;
      end
    end
    word = AXI4_DATA_WIDTH'({8'h00, grp[0], 8'h00, grp[1], 8'h00, grp[2], 8'h00, grp[3]});
  end

  always_comb begin
    wr_ok   = fifo_rst_n_d && (state_q == ACTIVE || state_q == LINE_REQ) && (line_cnt_q < V_DISP);
    wr_en_d = emit & wr_ok & ~full_r_q;
    ovf_evt = emit & wr_ok & full_r_q;
    data_d  = (emit && wr_ok) ? word : data_q;
  end

  // READY is used unregistered so the handshake is judged on the same edge that sees VALID
  always_comb begin
    valid_d = valid_q;
    bov_evt = 1'b0;
    if (valid_q && AXI_FULL_BURST_READY) valid_d = 1'b0;
    if (line_req) begin
      bov_evt = valid_q & ~AXI_FULL_BURST_READY;
      valid_d = 1'b1;
    end
    if (vs_rise) valid_d = 1'b0;
  end

  always_comb begin
    err_ovf_d = ERR_EN & ((err_ovf_q & ~clr_r_q) | ovf_evt);
    err_bov_d = ERR_EN & ((err_bov_q & ~clr_r_q) | bov_evt);
  end

  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      vs_r_q       <= 1'b0;
      vs_d1_q      <= 1'b0;
      de_r_q       <= 1'b0;
      de_d1_q      <= 1'b0;
      full_r_q     <= 1'b0;
      clr_r_q      <= 1'b0;
      data_r_q     <= '0;
      state_q      <= WAIT_VS;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      pix_buf_q    <= '0;
      data_q       <= '0;
      wr_en_q      <= 1'b0;
      valid_q      <= 1'b0;
      fifo_rst_n_q <= 1'b0;
      rst_cnt_q    <= '0;
      err_ovf_q    <= 1'b0;
      err_bov_q    <= 1'b0;
    end else begin
      vs_r_q       <= video_vs_in;
      vs_d1_q      <= vs_r_q;
      de_r_q       <= video_de_in;
      de_d1_q      <= de_r_q;
      full_r_q     <= fifo_full;
      clr_r_q      <= err_clr;
      data_r_q     <= video_data_in;
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      pix_buf_q    <= pix_buf_d;
      data_q       <= data_d;
      wr_en_q      <= wr_en_d;
      valid_q      <= valid_d;
      fifo_rst_n_q <= fifo_rst_n_d;
      rst_cnt_q    <= rst_cnt_d;
      err_ovf_q    <= err_ovf_d;
      err_bov_q    <= err_bov_d;
    end
  end

  assign fifo_data_out        = data_q;
  assign fifo_wr_en           = wr_en_q;
  assign fifo_rst_n           = fifo_rst_n_q;
  assign AXI_FULL_BURST_VALID = valid_q;
  assign frame_done           = (state_q == FRAME_END);
  assign err_overflow         = err_ovf_q;
  assign err_burst_overrun    = err_bov_q;

endmodule

// File: tb/tb_video_to_fifo_ctrl.sv
// Scoreboard bench for video_to_fifo_ctrl: two instances (8- and 6-pixel lines, 2 lines per frame).
module tb_video_to_fifo_ctrl;
  localparam int H0 = 8;
  localparam int H1 = 6;
  localparam int V  = 2;
`ifdef VIDEO_TO_FIFO_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [127:0] w;
    int           c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vs_in [2], hs_in [2], de_in [2], full_in [2], rdy_in [2], clr_in [2];
  logic [23:0]  px_in [2];
  logic [127:0] dout [2];
  logic         wr [2], frst_n [2], valid [2], fdone [2], eovf [2], ebov [2];

  int   cyc = 0;
  int   checks = 0, failures = 0;
  int   hs [2], fd [2];
  bit   frame_open [2];
  int   lines [2];
  exp_t q0 [$], q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  video_to_fifo_ctrl #(.H_DISP(12'd8), .V_DISP(12'd2), .AXI4_DATA_WIDTH(128), .FIFO_RST_CYCLES(8)) u_dut0 (
    .video_clk(clk), .video_rst_n(rst_n), .video_vs_in(vs_in[0]), .video_hs_in(hs_in[0]),
    .video_de_in(de_in[0]), .video_data_in(px_in[0]), .fifo_data_out(dout[0]), .fifo_wr_en(wr[0]),
    .fifo_full(full_in[0]), .fifo_rst_n(frst_n[0]), .AXI_FULL_BURST_VALID(valid[0]),
    .AXI_FULL_BURST_READY(rdy_in[0]), .frame_done(fdone[0]), .err_overflow(eovf[0]),
    .err_burst_overrun(ebov[0]), .err_clr(clr_in[0]));

  video_to_fifo_ctrl #(.H_DISP(12'd6), .V_DISP(12'd2), .AXI4_DATA_WIDTH(128), .FIFO_RST_CYCLES(8)) u_dut1 (
    .video_clk(clk), .video_rst_n(rst_n), .video_vs_in(vs_in[1]), .video_hs_in(hs_in[1]),
    .video_de_in(de_in[1]), .video_data_in(px_in[1]), .fifo_data_out(dout[1]), .fifo_wr_en(wr[1]),
    .fifo_full(full_in[1]), .fifo_rst_n(frst_n[1]), .AXI_FULL_BURST_VALID(valid[1]),
    .AXI_FULL_BURST_READY(rdy_in[1]), .frame_done(fdone[1]), .err_overflow(eovf[1]),
    .err_burst_overrun(ebov[1]), .err_clr(clr_in[1]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic monitor();
    exp_t e;
    bit   got;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_n) begin
          if (valid[d] && rdy_in[d]) hs[d]++;
          if (fdone[d]) fd[d]++;
          if (wr[d]) begin
            got = 1'b0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            if (!got) begin
              checks++;
              failures++;
              $display("FAIL unexpected_write dut%0d: got %h expected no write", d, dout[d]);
            end else begin
              check($sformatf("wr_data dut%0d", d), dout[d], e.w);
              check($sformatf("wr_cycle dut%0d", d), 128'(cyc), 128'(e.c));
            end
          end
        end
      end
    end
  endtask

  task automatic pulse_vs(input int d);
    int low = 0;
    vs_in[d] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (!frst_n[d]) low++;
      if (i == 1) vs_in[d] = 1'b0;
    end
    check($sformatf("fifo_rst_low_cycles dut%0d", d), 128'(low), 128'(8));
    frame_open[d] = 1'b1;
    lines[d]      = 0;
    tick();
  endtask

  // Model: a line produces writes only inside an open frame with fewer than V lines done
  task automatic drive_line(input int d, input bit seq, input int full_grp);
    logic [23:0]  px [$];
    logic [127:0] w;
    int           s, n, last;
    bit           live, chk_v;
    exp_t         e;
    n    = (d == 0) ? H0 : H1;
    live = frame_open[d] && (lines[d] < V);
    for (int i = 0; i < n; i++) px.push_back(seq ? 24'(i + 1) : 24'($urandom));
    tick();
    s     = cyc;
    chk_v = live && !valid[d];
    if (live) begin
      for (int g = 0; g < (n + 3) / 4; g++) begin
        w = '0;
        for (int k = 0; k < 4; k++)
          if (g * 4 + k < n) w[127 - 32 * k -: 32] = {8'h00, px[g * 4 + k]};
        last = (g * 4 + 3 < n) ? g * 4 + 3 : n - 1;
        if (g != full_grp) begin
          e.w = w;
          e.c = s + last + 2;
          if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      de_in[d]   = 1'b1;
      px_in[d]   = px[i];
      full_in[d] = (i / 4 == full_grp);
      tick();
    end
    de_in[d]   = 1'b0;
    px_in[d]   = '0;
    full_in[d] = 1'b0;
    if (chk_v) begin
      wait_cyc(s + n + 1);
      check($sformatf("valid_before_rise dut%0d", d), valid[d], 1'b0);
      wait_cyc(s + n + 2);
      check($sformatf("valid_rise dut%0d", d), valid[d], 1'b1);
      tick();
    end
    if (live) lines[d]++;
    repeat (8) tick();
  endtask

  task automatic pulse_clr(input int d);
    clr_in[d] = 1'b1;
    tick();
    clr_in[d] = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, expected finish before 2000000");
    $fatal(1);
  end

  initial begin
    int fd0, hs0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vs_in[d] = 1'b0; hs_in[d] = 1'b0; de_in[d] = 1'b0; full_in[d] = 1'b0;
      rdy_in[d] = 1'b0; clr_in[d] = 1'b0; px_in[d] = '0;
      hs[d] = 0; fd[d] = 0; frame_open[d] = 1'b0; lines[d] = 0;
    end
    fork monitor(); join_none
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_wr_en", wr[d], 1'b0);
      check("rst_data", dout[d], '0);
      check("rst_fifo_rst_n", frst_n[d], 1'b0);
      check("rst_valid", valid[d], 1'b0);
      check("rst_frame_done", fdone[d], 1'b0);
      check("rst_err_overflow", eovf[d], 1'b0);
      check("rst_err_overrun", ebov[d], 1'b0);
    end
    rst_n = 1'b1;
    tick();
    check("fifo_rst_release dut0", frst_n[0], 1'b1);
    check("fifo_rst_release dut1", frst_n[1], 1'b1);
    repeat (4) tick();

    // Basic frame, 8-pixel lines with a fixed first line
    rdy_in[0] = 1'b1;
    pulse_vs(0);
    fd0 = fd[0]; hs0 = hs[0];
    drive_line(0, 1'b1, -1);
    check("frame_done_after_line1", 128'(fd[0] - fd0), 128'(0));
    drive_line(0, 1'b0, -1);
    check("frame_done_after_line2", 128'(fd[0] - fd0), 128'(1));
    check("handshakes_per_frame", 128'(hs[0] - hs0), 128'(2));
    drive_line(0, 1'b0, -1);
    check("no_valid_after_frame", 128'(hs[0] - hs0), 128'(2));
    check("no_overrun_ready_high", ebov[0], 1'b0);

    // Partial group on 6-pixel lines
    rdy_in[1] = 1'b1;
    pulse_vs(1);
    fd0 = fd[1];
    drive_line(1, 1'b1, -1);
    drive_line(1, 1'b0, -1);
    check("frame_done_dut1", 128'(fd[1] - fd0), 128'(1));

    // READY held low across two line ends
    rdy_in[0] = 1'b0;
    pulse_vs(0);
    hs0 = hs[0];
    drive_line(0, 1'b0, -1);
    drive_line(0, 1'b0, -1);
    check("valid_held", valid[0], 1'b1);
    check("err_burst_overrun_set", ebov[0], ERR_EXP);
    rdy_in[0] = 1'b1;
    repeat (4) tick();
    check("single_handshake", 128'(hs[0] - hs0), 128'(1));
    check("valid_dropped", valid[0], 1'b0);
    pulse_clr(0);
    check("err_burst_overrun_clr", ebov[0], 1'b0);

    // FIFO full during second group
    pulse_vs(0);
    drive_line(0, 1'b0, 1);
    check("err_overflow_set", eovf[0], ERR_EXP);
    drive_line(0, 1'b0, -1);
    check("err_overflow_sticky", eovf[0], ERR_EXP);
    pulse_clr(0);
    check("err_overflow_clr", eovf[0], 1'b0);

    // VS mid-frame restarts line counting and drops a pending request
    rdy_in[0] = 1'b0;
    pulse_vs(0);
    drive_line(0, 1'b0, -1);
    check("valid_pending_before_vs", valid[0], 1'b1);
    pulse_vs(0);
    check("vs_clears_valid", valid[0], 1'b0);
    rdy_in[0] = 1'b1;
    fd0 = fd[0]; hs0 = hs[0];
    drive_line(0, 1'b0, -1);
    check("restart_line1_no_frame_done", 128'(fd[0] - fd0), 128'(0));
    drive_line(0, 1'b0, -1);
    check("restart_frame_done", 128'(fd[0] - fd0), 128'(1));
    check("restart_handshakes", 128'(hs[0] - hs0), 128'(2));

    // Reset mid-line
    pulse_vs(1);
    for (int i = 0; i < 3; i++) begin
      de_in[1] = 1'b1;
      px_in[1] = 24'($urandom);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr[1], 1'b0);
    check("midrst_data", dout[1], '0);
    check("midrst_fifo_rst_n", frst_n[1], 1'b0);
    check("midrst_valid", valid[1], 1'b0);
    check("midrst_frame_done", fdone[1], 1'b0);
    de_in[1] = 1'b0;
    px_in[1] = '0;
    frame_open[0] = 1'b0;
    frame_open[1] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("midrst_fifo_rst_release", frst_n[1], 1'b1);
    repeat (6) tick();
    drive_line(1, 1'b0, -1);
    pulse_vs(1);
    drive_line(1, 1'b0, -1);

    repeat (20) tick();
    check("queue0_drained", 128'(q0.size()), 128'(0));
    check("queue1_drained", 128'(q1.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
